// File: rtl/ddr_arbiter_rr.sv
// Purpose: arbitrates NUM_CH request channels onto one DDR command port and routes read data back to its owner.
// Latency: ack/cmd_valid one edge after the grant decision; rd_valid/rd_data one edge after ddr_rd_valid.
// Backpressure: no grant while cmd_busy, !init_done or a command is on the port; reads stall while the owner FIFO is full.
module ddr_arbiter_rr #(
  parameter int NUM_CH    = 5,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 4,
  parameter int RR_MODE   = 1
) (
  input  logic                     clk_133M,
  input  logic                     rst_133M,
  input  logic                     init_done,
  input  logic                     cmd_busy,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wr_data,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_CH-1:0]        rd_valid,
  output logic                     busy,
  output logic                     rd_err,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  output logic [ADDR_W-1:0]        ddr_address,
  output logic [DATA_W-1:0]        ddr_wr_data,
  input  logic [DATA_W-1:0]        ddr_rd_data,
  input  logic                     ddr_rd_valid
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] CMD_WR = 4'b0100;
  localparam logic [3:0] CMD_RD = 4'b0011;

  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   own_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  own_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [NUM_CH-1:0] eligible;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              push;
  logic              pop;

  // Channel visited at step k of the search: rotating after the last winner, or plain index order.
  function automatic logic [CH_W-1:0] search_idx(input logic [CH_W-1:0] base, input int unsigned k);
    int unsigned pos;
    if (RR_MODE != 0) pos = (32'(base) + k + 32'd1) % NUM_CH;
    else              pos = k;
    return CH_W'(pos);
  endfunction

  assign fifo_full  = (own_cnt == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (own_cnt == '0);

  // A command still on the port (ack/cmd_valid high) blocks the next grant, giving 2-cycle spacing.
  assign busy     = (|ack) | cmd_valid | cmd_busy | ~init_done;
  // Writes never need an owner slot, so only reads are held back by a full FIFO.
  assign eligible = req & (req_we | {NUM_CH{~fifo_full}});

  assign push = grant_vld & ~sel_we;
  assign pop  = ddr_rd_valid & ~fifo_empty;

  // Pick the first eligible channel in search order when the port is free.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!busy) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && eligible[search_idx(last_grant, k)]) begin
          grant_vld = 1'b1;
          grant_idx = search_idx(last_grant, k);
        end
      end
    end
  end

  // Mux the winning channel's direction, address and write data.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register the grant onto the command port as one-cycle ack/cmd_valid pulses.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      ack         <= '0;
      cmd_valid   <= 1'b0;
      cmd         <= '0;
      ddr_address <= '0;
      ddr_wr_data <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
    end else begin
      ack       <= '0;
      cmd_valid <= 1'b0;
      if (grant_vld) begin
        ack         <= NUM_CH'(1) << grant_idx;
        cmd_valid   <= 1'b1;
        last_grant  <= grant_idx;
        ddr_address <= sel_addr;
        if (sel_we) begin
          cmd         <= CMD_WR;
          ddr_wr_data <= sel_wdata;
        end else begin
          cmd <= CMD_RD;
        end
      end
    end
  end

  // Owner FIFO storage: records which channel each outstanding read belongs to.
  always_ff @(posedge clk_133M) begin
    if (push) own_mem[wr_ptr] <= grant_idx;
  end

  // Owner FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      own_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      own_cnt <= own_cnt + CNT_W'(1);
      else if (pop && !push) own_cnt <= own_cnt - CNT_W'(1);
    end
  end

  // Return read data to the FIFO-head owner; data with no owner is dropped and flagged.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      rd_valid <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= '0;
      if (pop) begin
        rd_valid <= NUM_CH'(1) << own_mem[rd_ptr];
        rd_data  <= ddr_rd_data;
      end
      if (ddr_rd_valid && fifo_empty) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_arbiter_rr.sv
module tb_ddr_arbiter_rr;
  localparam int NUM_CH    = 5;
  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 128;
  localparam int TAG_DEPTH = 4;

  logic                     clk_133M;
  logic                     rst_133M;
  logic                     init_done;
  logic                     cmd_busy;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wr_data;
  logic [DATA_W-1:0]        ddr_rd_data;
  logic                     ddr_rd_valid;

  logic [NUM_CH-1:0]        ack, rd_valid;
  logic [DATA_W-1:0]        rd_data, ddr_wr_data;
  logic                     busy, rd_err, cmd_valid;
  logic [3:0]               cmd;
  logic [ADDR_W-1:0]        ddr_address;

  logic [NUM_CH-1:0]        fp_ack, fp_rd_valid;
  logic [DATA_W-1:0]        fp_rd_data, fp_ddr_wr_data;
  logic                     fp_busy, fp_rd_err, fp_cmd_valid;
  logic [3:0]               fp_cmd;
  logic [ADDR_W-1:0]        fp_ddr_address;

  int total = 0;
  int bad   = 0;

  ddr_arbiter_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH), .RR_MODE(1)) dut (
    .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done), .cmd_busy(cmd_busy),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .ack(ack), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .rd_err(rd_err),
    .cmd(cmd), .cmd_valid(cmd_valid), .ddr_address(ddr_address), .ddr_wr_data(ddr_wr_data),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid));

  ddr_arbiter_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH), .RR_MODE(0)) dut_fp (
    .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done), .cmd_busy(cmd_busy),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .ack(fp_ack), .rd_data(fp_rd_data), .rd_valid(fp_rd_valid), .busy(fp_busy), .rd_err(fp_rd_err),
    .cmd(fp_cmd), .cmd_valid(fp_cmd_valid), .ddr_address(fp_ddr_address), .ddr_wr_data(fp_ddr_wr_data),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid));

  initial begin
    clk_133M = 1'b0;
    forever #5 clk_133M = ~clk_133M;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (round-robin instance) ----------------
  int                 m_last;
  int                 own_q[$];
  logic [NUM_CH-1:0]  m_ack, m_rdv;
  logic               m_cv, m_err;
  logic [3:0]         m_cmd;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_wdata, m_rdata;

  task automatic model_reset();
    m_last = NUM_CH - 1;
    own_q.delete();
    m_ack = '0; m_rdv = '0; m_cv = 1'b0; m_err = 1'b0;
    m_cmd = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [NUM_CH-1:0] elig;
    bit port_busy, found;
    int g;
    port_busy = (m_ack != 0) || m_cv || cmd_busy || !init_done;
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = req[i] && (req_we[i] || (own_q.size() < TAG_DEPTH));
    found = 0;
    g = 0;
    if (!port_busy)
      for (int k = 1; k <= NUM_CH; k++)
        if (!found && elig[(m_last + k) % NUM_CH]) begin
          found = 1;
          g = (m_last + k) % NUM_CH;
        end
    m_rdv = '0;
    if (ddr_rd_valid) begin
      if (own_q.size() == 0) m_err = 1'b1;
      else begin
        m_rdv[own_q.pop_front()] = 1'b1;
        m_rdata = ddr_rd_data;
      end
    end
    m_ack = '0;
    m_cv  = 1'b0;
    if (found) begin
      m_ack[g] = 1'b1;
      m_cv     = 1'b1;
      m_last   = g;
      m_addr   = req_addr[g*ADDR_W +: ADDR_W];
      if (req_we[g]) begin
        m_cmd   = 4'b0100;
        m_wdata = req_wr_data[g*DATA_W +: DATA_W];
      end else begin
        m_cmd = 4'b0011;
        own_q.push_back(g);
      end
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, ".ack"},       128'(ack),         128'(m_ack));
    check({tag, ".cmd_valid"}, 128'(cmd_valid),   128'(m_cv));
    check({tag, ".cmd"},       128'(cmd),         128'(m_cmd));
    check({tag, ".addr"},      128'(ddr_address), 128'(m_addr));
    check({tag, ".wdata"},     128'(ddr_wr_data), 128'(m_wdata));
    check({tag, ".rd_valid"},  128'(rd_valid),    128'(m_rdv));
    check({tag, ".rd_data"},   128'(rd_data),     128'(m_rdata));
    check({tag, ".rd_err"},    128'(rd_err),      128'(m_err));
    check({tag, ".busy"},      128'(busy),        128'((m_ack != 0) || m_cv || cmd_busy || !init_done));
  endtask

  task automatic do_reset();
    @(negedge clk_133M);
    rst_133M = 1'b1;
    req = '0; req_we = '0; ddr_rd_valid = 1'b0; cmd_busy = 1'b0; init_done = 1'b1;
    repeat (2) @(negedge clk_133M);
    rst_133M = 1'b0;
    model_reset();
  endtask

  // Waits (bounded) for any ack on the round-robin instance; returns at a falling edge.
  task automatic wait_ack(input logic [NUM_CH-1:0] want, input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk_133M); #1;
      if (ack != '0) begin
        got = 1;
        check(name, 128'(ack), 128'(want));
      end
      @(negedge clk_133M);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s: no ack within 20 cycles, expected %0h", name, want);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
      req_wr_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
    end
    ddr_rd_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- table of per-cycle vectors ----------------
  typedef struct {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] we;
    logic              rdv;
    logic [NUM_CH-1:0] exp_ack;
    logic              exp_cv;
    logic [3:0]        exp_cmd;
    logic [NUM_CH-1:0] exp_rdv;
    logic              exp_busy;
    logic [NUM_CH-1:0] exp_fp_ack;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // All channels reading: RR order 0,1,2,3, FIFO full, pop, 4, full again, pop, 0.
    tbl[0]  = '{5'h1F, 5'h00, 1'b0, 5'h01, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};
    tbl[1]  = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[2]  = '{5'h1F, 5'h00, 1'b0, 5'h02, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};
    tbl[3]  = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[4]  = '{5'h1F, 5'h00, 1'b0, 5'h04, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};
    tbl[5]  = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[6]  = '{5'h1F, 5'h00, 1'b0, 5'h08, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};
    tbl[7]  = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[8]  = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[9]  = '{5'h1F, 5'h00, 1'b1, 5'h00, 1'b0, 4'h3, 5'h01, 1'b0, 5'h00};
    tbl[10] = '{5'h1F, 5'h00, 1'b0, 5'h10, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};
    tbl[11] = '{5'h1F, 5'h00, 1'b0, 5'h00, 1'b0, 4'h3, 5'h00, 1'b0, 5'h00};
    tbl[12] = '{5'h1F, 5'h00, 1'b1, 5'h00, 1'b0, 4'h3, 5'h02, 1'b0, 5'h00};
    tbl[13] = '{5'h1F, 5'h00, 1'b0, 5'h01, 1'b1, 4'h3, 5'h00, 1'b1, 5'h01};

    rst_133M = 1'b1;
    init_done = 1'b1; cmd_busy = 1'b0;
    req = '0; req_we = '0; ddr_rd_valid = 1'b0;
    req_addr = '0; req_wr_data = '0; ddr_rd_data = '0;

    // ---- reset state ----
    do_reset();
    check("rst.ack",       128'(ack),         128'(0));
    check("rst.cmd_valid", 128'(cmd_valid),   128'(0));
    check("rst.cmd",       128'(cmd),         128'(0));
    check("rst.addr",      128'(ddr_address), 128'(0));
    check("rst.wdata",     128'(ddr_wr_data), 128'(0));
    check("rst.rd_valid",  128'(rd_valid),    128'(0));
    check("rst.rd_data",   128'(rd_data),     128'(0));
    check("rst.rd_err",    128'(rd_err),      128'(0));
    check("rst.busy",      128'(busy),        128'(0));
    init_done = 1'b0; #1;
    check("busy_no_init",  128'(busy),        128'(1));
    init_done = 1'b1; #1;

    // ---- table: RR order, spacing, FIFO full stall ----
    for (int r = 0; r < 14; r++) begin
      req = tbl[r].req; req_we = tbl[r].we; ddr_rd_valid = tbl[r].rdv;
      @(posedge clk_133M); #1;
      check($sformatf("tbl%0d.ack", r),    128'(ack),       128'(tbl[r].exp_ack));
      check($sformatf("tbl%0d.cv", r),     128'(cmd_valid), 128'(tbl[r].exp_cv));
      check($sformatf("tbl%0d.cmd", r),    128'(cmd),       128'(tbl[r].exp_cmd));
      check($sformatf("tbl%0d.rdv", r),    128'(rd_valid),  128'(tbl[r].exp_rdv));
      check($sformatf("tbl%0d.busy", r),   128'(busy),      128'(tbl[r].exp_busy));
      check($sformatf("tbl%0d.fp_ack", r), 128'(fp_ack),    128'(tbl[r].exp_fp_ack));
      @(negedge clk_133M);
    end

    // ---- fixed priority with req=10110 held (writes): always channel 1 ----
    do_reset();
    for (int c = 0; c < 8; c++) begin
      logic [NUM_CH-1:0] rr_exp [4];
      rr_exp[0] = 5'h02; rr_exp[1] = 5'h04; rr_exp[2] = 5'h10; rr_exp[3] = 5'h02;
      req = 5'b10110; req_we = 5'b10110;
      @(posedge clk_133M); #1;
      check($sformatf("fp_ack%0d", c), 128'(fp_ack), 128'((c % 2 == 0) ? 5'h02 : 5'h00));
      check($sformatf("rr_ack%0d", c), 128'(ack),    128'((c % 2 == 0) ? rr_exp[c/2] : 5'h00));
      @(negedge clk_133M);
    end

    // ---- read return order: ch3 then ch1, data A then B ----
    do_reset();
    req = 5'b01000; req_we = '0;
    wait_ack(5'b01000, "rd_ch3_ack");
    req = 5'b00010;
    wait_ack(5'b00010, "rd_ch1_ack");
    req = '0;
    ddr_rd_valid = 1'b1; ddr_rd_data = 128'hA;
    @(posedge clk_133M); #1;
    check("ret_a.rd_valid", 128'(rd_valid), 128'(5'b01000));
    check("ret_a.rd_data",  rd_data,        128'hA);
    @(negedge clk_133M);
    ddr_rd_data = 128'hB;
    @(posedge clk_133M); #1;
    check("ret_b.rd_valid", 128'(rd_valid), 128'(5'b00010));
    check("ret_b.rd_data",  rd_data,        128'hB);
    @(negedge clk_133M);
    ddr_rd_valid = 1'b0; ddr_rd_data = 128'hC;
    @(posedge clk_133M); #1;
    check("hold.rd_valid",  128'(rd_valid), 128'(0));
    check("hold.rd_data",   rd_data,        128'hB);
    check("hold.rd_err",    128'(rd_err),   128'(0));
    @(negedge clk_133M);

    // ---- FIFO full: write still granted, read waits for a pop ----
    do_reset();
    req_wr_data[2*DATA_W +: DATA_W] = 128'hD00D;
    req = 5'b00001; req_we = '0;
    for (int n = 0; n < TAG_DEPTH; n++) wait_ack(5'b00001, $sformatf("fill%0d", n));
    req = 5'b00101; req_we = 5'b00100;
    wait_ack(5'b00100, "wr_while_full");
    check("wr_while_full.cmd",   128'(cmd),   128'(4'b0100));
    check("wr_while_full.wdata", ddr_wr_data, 128'hD00D);
    req = 5'b00001; req_we = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_133M); #1;
      check($sformatf("rd_blocked%0d", c), 128'(ack), 128'(0));
      @(negedge clk_133M);
    end
    ddr_rd_valid = 1'b1;
    @(posedge clk_133M); #1;
    check("pop_full.ack", 128'(ack), 128'(0));
    @(negedge clk_133M);
    ddr_rd_valid = 1'b0;
    wait_ack(5'b00001, "rd_after_pop");
    check("rd_after_pop.cmd",   128'(cmd),   128'(4'b0011));
    check("rd_keeps_wdata",     ddr_wr_data, 128'hD00D);
    req = '0;

    // ---- orphan read data, then async reset mid-burst ----
    do_reset();
    ddr_rd_valid = 1'b1;
    @(posedge clk_133M); #1;
    check("orphan.rd_valid", 128'(rd_valid), 128'(0));
    check("orphan.rd_err",   128'(rd_err),   128'(1));
    @(negedge clk_133M);
    ddr_rd_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'(32'h100 + i);
      req_wr_data[i*DATA_W +: DATA_W] = 128'(32'h5500 + i);
    end
    req = 5'b00111; req_we = 5'b00010;
    repeat (5) begin
      @(posedge clk_133M);
      @(negedge clk_133M);
    end
    req = '0; ddr_rd_valid = 1'b1; ddr_rd_data = 128'hE;
    @(posedge clk_133M); #1;
    check("burst.rd_valid", 128'(rd_valid),    128'(5'b00001));
    check("burst.rd_data",  rd_data,           128'hE);
    check("burst.addr",     128'(ddr_address), 128'(32'h102));
    check("burst.rd_err",   128'(rd_err),      128'(1));
    #2 rst_133M = 1'b1;
    #1;
    check("arst.ack",       128'(ack),         128'(0));
    check("arst.rd_valid",  128'(rd_valid),    128'(0));
    check("arst.cmd_valid", 128'(cmd_valid),   128'(0));
    check("arst.rd_err",    128'(rd_err),      128'(0));
    check("arst.cmd",       128'(cmd),         128'(0));
    check("arst.addr",      128'(ddr_address), 128'(0));
    check("arst.wdata",     128'(ddr_wr_data), 128'(0));
    check("arst.rd_data",   rd_data,           128'(0));
    @(negedge clk_133M);
    ddr_rd_valid = 1'b0;
    @(negedge clk_133M);
    rst_133M = 1'b0;
    ddr_rd_valid = 1'b1;
    @(posedge clk_133M); #1;
    check("inflight_dropped.rd_valid", 128'(rd_valid), 128'(0));
    check("inflight_dropped.rd_err",   128'(rd_err),   128'(1));
    @(negedge clk_133M);
    ddr_rd_valid = 1'b0;

    // ---- randomized run against the model ----
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        req       = NUM_CH'($urandom);
        req_we    = NUM_CH'($urandom);
        cmd_busy  = ($urandom_range(0, 4) == 0);
        init_done = ($urandom_range(0, 19) != 0);
        ddr_rd_valid = (own_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 99) == 0);
        randomize_data();
        model_step();
        @(posedge clk_133M); #1;
        check_vs_model($sformatf("rnd%0d_%0d", phase, c));
        @(negedge clk_133M);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
